// File: rtl/mips_prog_pkg.sv
// Shared definitions for the instruction-memory programming path.
//   BYTE_W            - width of one program byte / memory write
//   IMEM_ADDR_W       - instruction address width, shared with instruction fetch
//   DEFAULT_MAX_BYTES - default largest program image accepted by the loader
//   prog_state_e      - loader sequencing states
//   gap_cnt_w()       - counter width needed for a release gap of a given length
package mips_prog_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned IMEM_ADDR_W       = 32;
    localparam int unsigned DEFAULT_MAX_BYTES = 1024;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StRelease,
        StRun
    } prog_state_e;

    // The timer counts from gap-1 down to 0, so it needs clog2(gap) bits (at least one).
    function automatic int unsigned gap_cnt_w(input int unsigned gap);
        return (gap > 1) ? $clog2(gap) : 1;
    endfunction

endpackage

// File: rtl/prog_release_timer.sv
// Down-counter that times the gap between En_Program rising and the CPU reset release.
//   clk     - system clock, rising edge
//   reset   - asynchronous active-low reset
//   load    - restart the gap (asserted on the cycle before the first RELEASE cycle)
//   tick    - count down one step (asserted during every RELEASE cycle)
//   expired - the current RELEASE cycle is the last one of the gap
module prog_release_timer
    import mips_prog_pkg::*;
#(
    parameter int unsigned RELEASE_GAP = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int unsigned CNT_W = gap_cnt_w(RELEASE_GAP);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(RELEASE_GAP - 1);
        end else if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/imem_program_loader.sv
// Programs the MicroProcessor instruction memory from a byte stream, then hands off to execution.
//   clk, reset          - system clock (rising edge), asynchronous active-low reset
//   start, byte_count   - begin a session loading byte_count bytes (0..MAX_BYTES)
//   rx_data/valid/ready - upstream byte stream, valid/ready handshake
//   mem_wr_en/addr/data - byte-wide instruction memory write port
//   En_Program          - 0 = programming mode, 1 = run mode
//   cpu_reset           - active-high reset to the MicroProcessor
//   busy, done, error   - status: loading/releasing, entry-to-RUN pulse, sticky bad length
module imem_program_loader
    import mips_prog_pkg::*;
#(
    parameter int unsigned ADDR_W      = IMEM_ADDR_W,
    parameter int unsigned MAX_BYTES   = DEFAULT_MAX_BYTES,
    parameter int unsigned RELEASE_GAP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] byte_count,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BYTE_W-1:0] mem_wr_data,
    output logic              En_Program,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    prog_state_e       state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              rx_ready_q, rx_ready_d;
    logic              wr_en_q, wr_en_d;
    logic              en_prog_q, en_prog_d;
    logic              cpu_reset_q, cpu_reset_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic accept;
    logic len_zero;
    logic len_illegal;
    logic timer_load;
    logic timer_tick;
    logic timer_expired;

    assign accept      = rx_valid & rx_ready_q;
    assign len_zero    = (byte_count == '0);
    assign len_illegal = (byte_count > ADDR_W'(MAX_BYTES));
    assign timer_tick  = (state_q == StRelease);

    prog_release_timer #(
        .RELEASE_GAP(RELEASE_GAP)
    ) u_release_timer (
        .clk    (clk),
        .reset  (reset),
        .load   (timer_load),
        .tick   (timer_tick),
        .expired(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        addr_d      = addr_q;
        data_d      = data_q;
        rx_ready_d  = 1'b0;
        wr_en_d     = 1'b0;
        en_prog_d   = en_prog_q;
        cpu_reset_d = cpu_reset_q;
        done_d      = 1'b0;
        error_d     = error_q;
        timer_load  = 1'b0;

        unique case (state_q)
            StIdle, StRun: begin
                if (start) begin
                    if (len_illegal) begin
                        // Bad length: flag it, leave the CPU exactly as it was.
                        error_d = 1'b1;
                    end else begin
                        error_d     = 1'b0;
                        len_d       = byte_count;
                        cnt_d       = '0;
                        cpu_reset_d = 1'b1;
                        if ((state_q == StIdle) && len_zero) begin
                            state_d    = StRelease;
                            en_prog_d  = 1'b1;
                            timer_load = 1'b1;
                        end else begin
                            // From RUN the CPU must be seen held for a cycle before
                            // En_Program can rise again; an empty session gets that
                            // cycle in LOAD, which exits at once since cnt == len.
                            state_d    = StLoad;
                            en_prog_d  = 1'b0;
                            rx_ready_d = !len_zero;
                        end
                    end
                end
            end

            StLoad: begin
                if (accept) begin
                    wr_en_d = 1'b1;
                    addr_d  = cnt_q;
                    data_d  = rx_data;
                    cnt_d   = cnt_q + ADDR_W'(1);
                end
                rx_ready_d = (cnt_d < len_q);
                // cnt reaches len in the cycle the final write strobe is on the port.
                if (cnt_q == len_q) begin
                    state_d    = StRelease;
                    en_prog_d  = 1'b1;
                    timer_load = 1'b1;
                    rx_ready_d = 1'b0;
                end
            end

            StRelease: begin
                if (timer_expired) begin
                    state_d     = StRun;
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d == StLoad) || (state_d == StRelease);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rx_ready_q  <= 1'b0;
            wr_en_q     <= 1'b0;
            en_prog_q   <= 1'b0;
            cpu_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rx_ready_q  <= rx_ready_d;
            wr_en_q     <= wr_en_d;
            en_prog_q   <= en_prog_d;
            cpu_reset_q <= cpu_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    assign rx_ready    = rx_ready_q;
    assign mem_wr_en   = wr_en_q;
    assign mem_addr    = addr_q;
    assign mem_wr_data = data_q;
    assign En_Program  = en_prog_q;
    assign cpu_reset   = cpu_reset_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Directed-plus-random bench for imem_program_loader: a byte source drives the handshake,
// a negedge monitor logs every write and the En_Program / cpu_reset / done events, and each
// session is compared with the expected image (byte i at address i) and hand-off timing.
module tb_imem_program_loader;

    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MAX_BYTES = 64;
    localparam int unsigned GAP       = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] byte_count = '0;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wr_data;
    logic              En_Program;
    logic              cpu_reset;
    logic              busy;
    logic              done;
    logic              error;

    imem_program_loader #(
        .ADDR_W     (ADDR_W),
        .MAX_BYTES  (MAX_BYTES),
        .RELEASE_GAP(GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_count (byte_count),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_wr_en  (mem_wr_en),
        .mem_addr   (mem_addr),
        .mem_wr_data(mem_wr_data),
        .En_Program (En_Program),
        .cpu_reset  (cpu_reset),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled mid-cycle, away from the active edge.
    logic [ADDR_W-1:0] wr_addr_log[$];
    logic [7:0]        wr_data_log[$];
    int   last_wr_cyc = -1;
    int   en_rise_cyc = -1;
    int   rst_fall_cyc = -1;
    int   done_cnt = 0;
    logic en_prev = 1'b0;
    logic rst_prev = 1'b1;

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wr_data);
            last_wr_cyc = cyc;
        end
        if (En_Program && !en_prev) en_rise_cyc = cyc;
        if (!cpu_reset && rst_prev) rst_fall_cyc = cyc;
        if (done) done_cnt++;
        en_prev  = En_Program;
        rst_prev = cpu_reset;
    end

    logic [7:0] prog [MAX_BYTES];
    logic [7:0] table16 [16] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h0C, 8'h0F, 8'h29, 8'hE4,
                                 8'h1A, 8'h81, 8'h31, 8'hD2, 8'hD9, 8'h02, 8'h7F, 8'h51};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_random(input int unsigned n);
        for (int i = 0; i < int'(n); i++) prog[i] = 8'($urandom);
    endtask

    // Source: mode 0 = valid always, 1 = valid every other cycle, 2 = random valid.
    task automatic send(input int unsigned n, input int mode);
        int unsigned i;
        int          k;
        bit          acc;
        i = 0;
        k = 0;
        while ((i < n) && (k < int'(4 * n + 20))) begin
            rx_data  = prog[i];
            rx_valid = (mode == 0) ? 1'b1 : (mode == 1) ? ((k % 2) == 0) : 1'($urandom_range(0, 1));
            acc      = rx_valid && rx_ready;
            tick();
            k++;
            if (acc) i++;
        end
        rx_valid = 1'b0;
        check("send_complete", 64'(i), 64'(n));
    endtask

    task automatic clear_log();
        wr_addr_log.delete();
        wr_data_log.delete();
        last_wr_cyc  = -1;
        en_rise_cyc  = -1;
        rst_fall_cyc = -1;
        done_cnt     = 0;
    endtask

    // One full session; n == 0 is only used from IDLE.
    task automatic run_session(input int unsigned n, input int mode);
        int s;
        int exp_en;
        clear_log();
        start      = 1'b1;
        byte_count = ADDR_W'(n);
        s          = cyc;
        tick();
        start = 1'b0;
        check("start_cpu_reset", 64'(cpu_reset), 64'(1));
        check("start_en_program", 64'(En_Program), 64'(n == 0));
        check("start_busy", 64'(busy), 64'(1));
        check("start_error", 64'(error), 64'(0));
        check("start_rx_ready", 64'(rx_ready), 64'(n != 0));
        send(n, mode);
        repeat (GAP + 6) tick();
        check("wr_count", 64'(wr_addr_log.size()), 64'(n));
        for (int i = 0; i < wr_addr_log.size() && i < int'(n); i++) begin
            check($sformatf("wr_addr[%0d]", i), 64'(wr_addr_log[i]), 64'(i));
            check($sformatf("wr_data[%0d]", i), 64'(wr_data_log[i]), 64'(prog[i]));
        end
        exp_en = (n == 0) ? s + 1 : last_wr_cyc + 1;
        check("en_rise_cycle", 64'(en_rise_cyc), 64'(exp_en));
        check("cpu_release_cycle", 64'(rst_fall_cyc), 64'(exp_en + int'(GAP)));
        check("done_pulses", 64'(done_cnt), 64'(1));
        check("run_en_program", 64'(En_Program), 64'(1));
        check("run_cpu_reset", 64'(cpu_reset), 64'(0));
        check("run_busy", 64'(busy), 64'(0));
        check("run_rx_ready", 64'(rx_ready), 64'(0));
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n;
        reset = 1'b0;
        repeat (3) tick();
        check("rst_rx_ready", 64'(rx_ready), 64'(0));
        check("rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wr_data", 64'(mem_wr_data), 64'(0));
        check("rst_en_program", 64'(En_Program), 64'(0));
        check("rst_cpu_reset", 64'(cpu_reset), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        reset = 1'b1;
        tick();

        // Fixed 16-byte program, streaming and then with gaps (second run starts from RUN).
        for (int i = 0; i < 16; i++) prog[i] = table16[i];
        run_session(16, 0);
        run_session(16, 1);

        // Oversized request while running: flagged, CPU keeps running.
        start      = 1'b1;
        byte_count = ADDR_W'(MAX_BYTES + 1 + $urandom_range(0, 100));
        tick();
        start = 1'b0;
        check("run_bad_error", 64'(error), 64'(1));
        check("run_bad_cpu_reset", 64'(cpu_reset), 64'(0));
        check("run_bad_en_program", 64'(En_Program), 64'(1));
        repeat (3) tick();
        check("run_bad_busy", 64'(busy), 64'(0));
        check("run_bad_still_running", 64'(cpu_reset), 64'(0));

        // Re-program 4 bytes from RUN; the legal start clears the error.
        fill_random(4);
        run_session(4, 2);

        // Reset in the middle of a 16-byte load, right as the 5th write is on the port.
        fill_random(16);
        clear_log();
        start      = 1'b1;
        byte_count = ADDR_W'(16);
        tick();
        start = 1'b0;
        send(5, 0);
        check("pre_reset_write_pending", 64'(mem_wr_en), 64'(1));
        reset = 1'b0;
        #1;
        check("mid_reset_wr_en", 64'(mem_wr_en), 64'(0));
        check("mid_reset_cpu_reset", 64'(cpu_reset), 64'(1));
        check("mid_reset_en_program", 64'(En_Program), 64'(0));
        check("mid_reset_rx_ready", 64'(rx_ready), 64'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Oversized request from IDLE: stays idle with the CPU held.
        start      = 1'b1;
        byte_count = ADDR_W'(MAX_BYTES + 1);
        tick();
        start = 1'b0;
        check("idle_bad_error", 64'(error), 64'(1));
        check("idle_bad_rx_ready", 64'(rx_ready), 64'(0));
        check("idle_bad_cpu_reset", 64'(cpu_reset), 64'(1));
        repeat (3) tick();
        check("idle_bad_busy", 64'(busy), 64'(0));
        check("idle_bad_en_program", 64'(En_Program), 64'(0));

        // Fresh session after the aborted one must write from address 0 again.
        n = $urandom_range(1, MAX_BYTES);
        fill_random(n);
        run_session(n, 2);

        // Empty program from IDLE: straight to release, no writes.
        apply_reset();
        run_session(0, 0);

        // Largest legal program, then a few random sessions.
        fill_random(MAX_BYTES);
        run_session(MAX_BYTES, 2);
        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, MAX_BYTES);
            fill_random(n);
            run_session(n, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
